mmio_gpio_hub: RTL and testbench
================================

Name: mmio_gpio_hub

Overview:
- Parametrised memory-mapped GPIO controller for the single-cycle MIPS CPU; replaces the separate LED, switch and single-button blocks with one block.
- Adds per-channel button debounce, sticky press/release status with write-1-to-clear, an IRQ mask/line, and an LED enable.
- Sits behind the MemOrIO address decode, driven from the IO chip-select and the ALU-result address.

Parameters:
LED_W, 24, LED output width (1..32)
SW_W, 24, switch input width (1..32)
BTN_N, 4, number of button channels (1..32)
DB_CYCLES, 230000, cycles a synchronised button must remain stable before it is accepted (about 10 ms at 23 MHz; minimum 2)

Ports:
clk  in  1  CPU clock; all state is clocked on its rising edge
rst_n  in  1  asynchronous active-low reset
io_cs  in  1  IO window select from the address decode
io_addr  in  3  word offset within the window (CPU address bits [4:2])
io_read  in  1  read strobe
io_write  in  1  write strobe
io_wdata  in  32  write data
io_rdata  out  32  read data
switch_i  in  SW_W  raw asynchronous switch inputs
button_i  in  BTN_N  raw asynchronous button inputs
leds  out  LED_W  LED drive
irq  out  1  level interrupt request

Behaviour:
- Reset (async on rst_n=0, released synchronously):
  - led_reg, all syncs, debounce counters, btn_stable, press, release and mask are 0.
  - led_en is 1.
  - leds=0, irq=0, io_rdata=0.
  - Reset asserted mid-debounce discards the count.
- Register map (io_addr value, access, content):
  - 0 LED, RW, led_reg[LED_W-1:0].
  - 1 SW, RO, synchronised switches.
  - 2 BTN, RO, debounced levels.
  - 3 PRESS, W1C, sticky rising edges.
  - 4 RELEASE, W1C, sticky falling edges.
  - 5 MASK, RW, IRQ mask for PRESS bits.
  - 6 CTRL, RW, bit0 = led_en.
  - 7 reserved: reads 0, writes ignored.
- Width rules: unused upper bits read 0. Writes truncate io_wdata to the register width.
- Read path:
  - io_rdata is combinational from registered state when io_cs & io_read, otherwise 0.
  - Zero-wait; no handshake.
- Write path: when io_cs & io_write, the register updates on the next rising clk edge. Writes with io_cs=0 are ignored.
- Simultaneous read and write to the same offset: the read returns the pre-write value.
- leds = led_en ? led_reg : 0, registered. Clearing led_en does not alter led_reg.
- Switches: 2-FF synchroniser, no debounce. The SW register reflects an input change after 2 clk edges.
- Button channel (each independent):
  - 2-FF synchroniser producing sync.
  - If sync == stable: counter clears to 0.
  - Otherwise the counter increments. When the counter reaches DB_CYCLES-1 and sync still differs: stable <= sync and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes stable.
  - Counter width is clog2(DB_CYCLES); the counter never wraps.
- Edge status:
  - stable 0->1 sets press[i]; stable 1->0 sets release[i].
  - A W1C write clears the bits written as 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- irq = |(press & mask), registered (one cycle after the press bit sets). Drops the cycle after press is cleared or masked.

Decomposition:
- Shared package gpio_pkg:
  - Register offset constants: REG_LED=0, REG_SW=1, REG_BTN=2, REG_PRESS=3, REG_REL=4, REG_MASK=5, REG_CTRL=6.
  - CTRL bit index LED_EN_BIT=0.
- Sub-module btn_debounce (parameter DB_CYCLES):
  - Ports clk, rst_n, raw, level, rise, fall.
  - Instantiated BTN_N times in a generate loop.

Test Plan (bench uses DB_CYCLES=4, LED_W=24, SW_W=24, BTN_N=4):
1. Write LED 0xFFABCDEF -> leds=0xABCDEF after the next edge; read offset 0 = 0x00ABCDEF. Write CTRL=0 -> leds=0 while the read-back is still 0x00ABCDEF. Write CTRL=1 -> leds=0xABCDEF.
2. Glitch on button_i[0]: high for 3 cycles then low -> BTN=0, PRESS=0. Hold high -> BTN[0]=1 exactly 2+4 cycles after the input edge, with PRESS=0x1. Release the same way -> RELEASE=0x1.
3. Write PRESS=0x1 in the same cycle button 1's stable level rises -> PRESS=0x2, bit0 cleared. Writing 0 leaves it unchanged.
4. MASK=0x2: press button 0 -> irq=0. Press button 1 -> irq=1 one cycle after PRESS[1] sets. Write PRESS=0x2 -> irq=0 the following cycle.
5. switch_i=0x123456 -> SW reads 0x123456 from the 2nd edge. Read offset 7 -> 0. Read with io_cs=0 -> 0.
6. Assert rst_n=0 asynchronously mid-debounce with leds and irq active -> leds=0 and irq=0 immediately, CTRL reads 1. Debounce restarts from 0 after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register offsets and control bit positions for the memory-mapped GPIO hub.
package gpio_pkg;

  localparam logic [2:0] REG_LED   = 3'd0;
  localparam logic [2:0] REG_SW    = 3'd1;
  localparam logic [2:0] REG_BTN   = 3'd2;
  localparam logic [2:0] REG_PRESS = 3'd3;
  localparam logic [2:0] REG_REL   = 3'd4;
  localparam logic [2:0] REG_MASK  = 3'd5;
  localparam logic [2:0] REG_CTRL  = 3'd6;

  localparam int LED_EN_BIT = 0;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser followed by a stability counter.
// rise/fall strobe in the cycle whose closing edge updates level.
module btn_debounce #(
  parameter int DB_CYCLES = 230000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync2 != stable) && (cnt == LAST);
  assign level  = stable;
  assign rise   = accept & sync2;
  assign fall   = accept & ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_gpio_hub.sv
// Memory-mapped GPIO hub: LEDs, synchronised switches, debounced buttons with
// sticky W1C press/release status and a maskable level interrupt.
module mmio_gpio_hub
  import gpio_pkg::*;
#(
  parameter int LED_W     = 24,
  parameter int SW_W      = 24,
  parameter int BTN_N     = 4,
  parameter int DB_CYCLES = 230000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_cs,
  input  logic [2:0]       io_addr,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  input  logic [SW_W-1:0]  switch_i,
  input  logic [BTN_N-1:0] button_i,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  logic             wr;
  logic             rd;
  logic [LED_W-1:0] led_reg, led_reg_nxt;
  logic             led_en, led_en_nxt;
  logic [LED_W-1:0] leds_q;
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [BTN_N-1:0] btn_level, btn_rise, btn_fall;
  logic [BTN_N-1:0] press, rel, mask, mask_nxt;
  logic [BTN_N-1:0] press_clr, rel_clr;
  logic             irq_q;
  logic             unused_wdata;

  assign wr           = io_cs & io_write;
  assign rd           = io_cs & io_read;
  assign unused_wdata = ^io_wdata;

  for (genvar i = 0; i < BTN_N; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (button_i[i]),
      .level(btn_level[i]),
      .rise (btn_rise[i]),
      .fall (btn_fall[i])
    );
  end

  always_comb begin
    led_reg_nxt = led_reg;
    led_en_nxt  = led_en;
    mask_nxt    = mask;
    press_clr   = '0;
    rel_clr     = '0;
    if (wr) begin
      case (io_addr)
        REG_LED:   led_reg_nxt = io_wdata[LED_W-1:0];
        REG_PRESS: press_clr   = io_wdata[BTN_N-1:0];
        REG_REL:   rel_clr     = io_wdata[BTN_N-1:0];
        REG_MASK:  mask_nxt    = io_wdata[BTN_N-1:0];
        REG_CTRL:  led_en_nxt  = io_wdata[LED_EN_BIT];
        default:   ;
      endcase
    end
  end

  // leds follows the post-write register values so a write shows on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg <= '0;
      led_en  <= 1'b1;
      leds_q  <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      press   <= '0;
      rel     <= '0;
      mask    <= '0;
      irq_q   <= 1'b0;
    end else begin
      led_reg <= led_reg_nxt;
      led_en  <= led_en_nxt;
      leds_q  <= led_en_nxt ? led_reg_nxt : '0;
      sw_s1   <= switch_i;
      sw_s2   <= sw_s1;
      // A new edge in the same cycle as its W1C clear keeps the bit set.
      press   <= (press & ~press_clr) | btn_rise;
      rel     <= (rel & ~rel_clr) | btn_fall;
      mask    <= mask_nxt;
      irq_q   <= |(press & mask);
    end
  end

  assign leds = leds_q;
  assign irq  = irq_q;

  always_comb begin
    io_rdata = '0;
    if (rd) begin
      case (io_addr)
        REG_LED:   io_rdata[LED_W-1:0] = led_reg;
        REG_SW:    io_rdata[SW_W-1:0]  = sw_s2;
        REG_BTN:   io_rdata[BTN_N-1:0] = btn_level;
        REG_PRESS: io_rdata[BTN_N-1:0] = press;
        REG_REL:   io_rdata[BTN_N-1:0] = rel;
        REG_MASK:  io_rdata[BTN_N-1:0] = mask;
        REG_CTRL:  io_rdata[LED_EN_BIT] = led_en;
        default:   io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_gpio_hub.sv
// Directed bench for mmio_gpio_hub; stimulus queues expectations, a negedge monitor checks them.
module tb_mmio_gpio_hub;

  localparam int LED_W = 24;
  localparam int SW_W  = 24;
  localparam int BTN_N = 4;
  localparam int DB    = 4;

  localparam int K_RDATA = 0;
  localparam int K_LEDS  = 1;
  localparam int K_IRQ   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             io_cs, io_read, io_write;
  logic [2:0]       io_addr;
  logic [31:0]      io_wdata, io_rdata;
  logic [SW_W-1:0]  switch_i;
  logic [BTN_N-1:0] button_i;
  logic [LED_W-1:0] leds;
  logic             irq;
  logic             probe;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  mmio_gpio_hub #(.LED_W(LED_W), .SW_W(SW_W), .BTN_N(BTN_N), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_cs   (io_cs),
    .io_addr (io_addr),
    .io_read (io_read),
    .io_write(io_write),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .switch_i(switch_i),
    .button_i(button_i),
    .leds    (leds),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((io_cs && io_read) || probe) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h required no output", io_rdata);
      end else begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.kind)
          K_LEDS:  act = 32'(leds);
          K_IRQ:   act = 32'(irq);
          default: act = io_rdata;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_write = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_cs = 1'b0; io_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = K_RDATA; e.exp = exp; e.name = name;
    q.push_back(e);
    io_cs = 1'b1; io_read = 1'b1; io_addr = a;
    tick();
    io_cs = 1'b0; io_read = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    q.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; io_cs = 1'b0; io_read = 1'b0; io_write = 1'b0;
    io_addr = '0; io_wdata = '0; switch_i = '0; button_i = '0; probe = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    tick();
    chk(K_LEDS, 32'h0, "reset_leds");
    chk(K_IRQ, 32'h0, "reset_irq");
    rd(3'd6, 32'h1, "reset_ctrl");
    rd(3'd0, 32'h0, "reset_led_reg");
    rd(3'd3, 32'h0, "reset_press");

    // LED and enable
    wr(3'd0, 32'hFFABCDEF);
    chk(K_LEDS, 32'hABCDEF, "leds_write");
    rd(3'd0, 32'h00ABCDEF, "led_readback");
    wr(3'd6, 32'h0);
    chk(K_LEDS, 32'h0, "leds_disabled");
    rd(3'd0, 32'h00ABCDEF, "led_reg_kept");
    rd(3'd6, 32'h0, "ctrl_zero");
    wr(3'd6, 32'h1);
    chk(K_LEDS, 32'hABCDEF, "leds_reenabled");

    // glitch of 3 cycles is rejected
    button_i[0] = 1'b1;
    ticks(3);
    button_i[0] = 1'b0;
    ticks(8);
    rd(3'd2, 32'h0, "glitch_btn");
    rd(3'd3, 32'h0, "glitch_press");
    // held press accepted exactly 6 edges after the input edge
    button_i[0] = 1'b1;
    ticks(5);
    rd(3'd2, 32'h0, "btn_before_accept");
    rd(3'd2, 32'h1, "btn_accepted");
    rd(3'd3, 32'h1, "press_set");
    button_i[0] = 1'b0;
    ticks(8);
    rd(3'd2, 32'h0, "btn_released");
    rd(3'd4, 32'h1, "release_set");
    wr(3'd4, 32'hF);
    rd(3'd4, 32'h0, "release_cleared");

    // W1C on the same edge as a new press: set wins, other bit clears
    button_i[1] = 1'b1;
    ticks(5);
    wr(3'd3, 32'h3);
    rd(3'd3, 32'h2, "w1c_set_wins");
    wr(3'd3, 32'h0);
    rd(3'd3, 32'h2, "w1c_zero_noop");
    rd(3'd2, 32'h2, "btn_level_b1");

    // interrupt masking
    wr(3'd3, 32'hF);
    rd(3'd3, 32'h0, "press_all_cleared");
    wr(3'd5, 32'h2);
    rd(3'd5, 32'h2, "mask_readback");
    button_i[0] = 1'b1;
    ticks(8);
    chk(K_IRQ, 32'h0, "irq_masked");
    rd(3'd3, 32'h1, "press_b0_only");
    button_i[1] = 1'b0;
    ticks(8);
    button_i[1] = 1'b1;
    ticks(5);
    rd(3'd3, 32'h1, "press_b1_pending");
    chk(K_IRQ, 32'h0, "irq_not_yet");
    chk(K_IRQ, 32'h1, "irq_raised");
    wr(3'd3, 32'h2);
    chk(K_IRQ, 32'h1, "irq_lag");
    chk(K_IRQ, 32'h0, "irq_dropped");
    rd(3'd3, 32'h1, "press_after_clear");

    // switches, reserved offset, deselected access
    switch_i = 24'h123456;
    rd(3'd1, 32'h0, "sw_edge1");
    rd(3'd1, 32'h0, "sw_edge2");
    rd(3'd1, 32'h00123456, "sw_synced");
    wr(3'd7, 32'hFFFFFFFF);
    rd(3'd7, 32'h0, "reserved_read");
    io_write = 1'b1; io_addr = 3'd0; io_wdata = 32'h0;
    tick();
    io_write = 1'b0;
    rd(3'd0, 32'h00ABCDEF, "write_no_cs");
    io_read = 1'b1; io_addr = 3'd0;
    chk(K_RDATA, 32'h0, "read_no_cs");
    io_read = 1'b0;

    // async reset mid-debounce
    button_i = '0;
    ticks(8);
    wr(3'd5, 32'h3);
    tick();
    chk(K_IRQ, 32'h1, "irq_before_reset");
    button_i[2] = 1'b1;
    ticks(3);
    #2 rst_n = 1'b0;
    chk(K_LEDS, 32'h0, "reset_async_leds");
    chk(K_IRQ, 32'h0, "reset_async_irq");
    rd(3'd6, 32'h1, "reset_ctrl_en");
    rd(3'd5, 32'h0, "reset_mask");
    rd(3'd3, 32'h0, "reset_press2");
    rst_n = 1'b1;
    ticks(5);
    rd(3'd2, 32'h0, "db_restart_early");
    rd(3'd2, 32'h4, "db_restart_accept");
    chk(K_LEDS, 32'h0, "leds_after_reset");

    tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL unconsumed_expectations: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
